// File: rtl/cci_mpf_prim_fifo_lutram_pkg.sv
// Shared defaults and elaboration helpers for the LUTRAM-backed FIFO and its storage.
package cci_mpf_prim_fifo_lutram_pkg;

  localparam int unsigned DEFAULT_N_ENTRIES   = 32;
  localparam int unsigned DEFAULT_N_DATA_BITS = 64;
  localparam int unsigned DEFAULT_THRESHOLD   = 2;
  localparam int unsigned MIN_N_ENTRIES       = 4;

  // True when v is a nonzero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cci_mpf_prim_lutram.sv
// Distributed-RAM primitive: synchronous write, combinational read.
module cci_mpf_prim_lutram
  import cci_mpf_prim_fifo_lutram_pkg::*;
#(
  parameter int unsigned N_ENTRIES         = DEFAULT_N_ENTRIES,
  parameter int unsigned N_DATA_BITS       = DEFAULT_N_DATA_BITS,
  parameter              READ_DURING_WRITE = "OLD_DATA",
  localparam int unsigned ADDR_W           = $clog2(N_ENTRIES)
)(
  input  logic                   clk,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [N_DATA_BITS-1:0] rdata,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic                   wen,
  input  logic [N_DATA_BITS-1:0] wdata
);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  // Array write; contents are never reset, so stale data survives a FIFO reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of the address being written: NEW_DATA forwards wdata,
  // otherwise the pre-write contents are returned.
  if (READ_DURING_WRITE == "NEW_DATA") begin : g_new_data
    assign rdata = (wen && (waddr == raddr)) ? wdata : mem[raddr];
  end else begin : g_old_data
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Synchronous FIFO over a LUTRAM array with occupancy, full/almost-full
// flow control and a sticky protocol-error flag.
module cci_mpf_prim_fifo_lutram
  import cci_mpf_prim_fifo_lutram_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = DEFAULT_N_ENTRIES,
  parameter int unsigned N_DATA_BITS = DEFAULT_N_DATA_BITS,
  parameter int unsigned THRESHOLD   = DEFAULT_THRESHOLD
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   notFull,
  output logic                   almostFull,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   notEmpty,
  output logic                   err
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] t_idx;
  typedef logic [CNT_W-1:0] t_cnt;

  localparam t_cnt CNT_FULL  = t_cnt'(N_ENTRIES);
  localparam t_cnt CNT_AFULL = t_cnt'(N_ENTRIES - THRESHOLD);

  t_idx wr_idx;
  t_idx rd_idx;
  t_cnt count;

  logic enq_ok;
  logic deq_ok;
  logic enq_err;
  logic deq_err;

  // Flow-control outputs depend only on registered occupancy.
  assign notFull    = (count != CNT_FULL);
  assign notEmpty   = (count != '0);
  assign almostFull = (count >= CNT_AFULL);

  // Accept/reject decisions from registered state; a full FIFO is not
  // relieved by a same-cycle dequeue.
  assign enq_ok  = enq_en && notFull;
  assign deq_ok  = deq_en && notEmpty;
  assign enq_err = enq_en && !notFull;
  assign deq_err = deq_en && !notEmpty;

  // Storage; the head entry is read combinationally at rd_idx.
  cci_mpf_prim_lutram #(
    .N_ENTRIES         (N_ENTRIES),
    .N_DATA_BITS       (N_DATA_BITS),
    .READ_DURING_WRITE ("OLD_DATA")
  ) mem (
    .clk   (clk),
    .raddr (rd_idx),
    .rdata (first),
    .waddr (wr_idx),
    .wen   (enq_ok),
    .wdata (enq_data)
  );

  // Pointer, occupancy and sticky error update; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (enq_ok) begin
        wr_idx <= wr_idx + t_idx'(1);
      end
      if (deq_ok) begin
        rd_idx <= rd_idx + t_idx'(1);
      end
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + t_cnt'(1);
        2'b01:   count <= count - t_cnt'(1);
        default: count <= count;
      endcase
      if (enq_err || deq_err) begin
        err <= 1'b1;
      end
    end
  end

  // Simulation-only checks: legal geometry and protocol misuse warnings.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (is_pow2(N_ENTRIES) && (N_ENTRIES >= MIN_N_ENTRIES) &&
              (THRESHOLD >= 1) && (THRESHOLD < N_ENTRIES))
        else $error("cci_mpf_prim_fifo_lutram: illegal N_ENTRIES/THRESHOLD");
    end else begin
      assert (!enq_err)
        else $warning("cci_mpf_prim_fifo_lutram: enqueue while full dropped");
      assert (!deq_err)
        else $warning("cci_mpf_prim_fifo_lutram: dequeue while empty ignored");
    end
  end

endmodule

// File: tb/tb_cci_mpf_prim_fifo_lutram.sv
// Self-checking bench for cci_mpf_prim_fifo_lutram: directed table, directed
// corner sequences and constrained-random traffic against a queue model.
module tb_cci_mpf_prim_fifo_lutram;

  localparam int unsigned N  = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned TH = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] enq_data;
  logic          enq_en;
  logic          notFull;
  logic          almostFull;
  logic [DW-1:0] first;
  logic          deq_en;
  logic          notEmpty;
  logic          err;

  cci_mpf_prim_fifo_lutram #(
    .N_ENTRIES   (N),
    .N_DATA_BITS (DW),
    .THRESHOLD   (TH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_data   (enq_data),
    .enq_en     (enq_en),
    .notFull    (notFull),
    .almostFull (almostFull),
    .first      (first),
    .deq_en     (deq_en),
    .notEmpty   (notEmpty),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the FIFO contents as a queue plus the sticky error bit.
  logic [DW-1:0] q[$];
  bit            m_err;

  typedef struct {
    bit            enq;
    bit            deq;
    logic [DW-1:0] data;
    bit            ne;
    bit            nf;
    bit            af;
    bit            er;
    bit            chk_first;
    logic [DW-1:0] fst;
  } vec_t;

  vec_t tbl[12];

  task automatic cmp1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmpw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    cmp1({tag, ".notEmpty"},   notEmpty,   q.size() != 0);
    cmp1({tag, ".notFull"},    notFull,    q.size() != int'(N));
    cmp1({tag, ".almostFull"}, almostFull, (int'(N) - q.size()) <= int'(TH));
    cmp1({tag, ".err"},        err,        m_err);
    if (q.size() != 0) begin
      cmpw({tag, ".first"}, first, q[0]);
    end
  endtask

  // Apply the FIFO rules to the model for one clock edge.
  task automatic model_step(input bit e, input bit d, input logic [DW-1:0] data);
    bit full;
    bit empty;
    full  = (q.size() == int'(N));
    empty = (q.size() == 0);
    if ((e && full) || (d && empty)) m_err = 1'b1;
    if (d && !empty) void'(q.pop_front());
    if (e && !full) q.push_back(data);
  endtask

  task automatic do_cycle(input string tag, input bit e, input bit d, input logic [DW-1:0] data);
    enq_en   = e;
    deq_en   = d;
    enq_data = data;
    model_step(e, d, data);
    @(posedge clk);
    #1;
    enq_en = 1'b0;
    deq_en = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enq_en = 1'b0;
    deq_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_err = 1'b0;
    check_all("reset");
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enq_en   = 1'b0;
    deq_en   = 1'b0;
    enq_data = '0;
    m_err    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed table: in-order drain, empty dequeue, bypass, empty enq+deq.
    tbl[0]  = '{1'b1, 1'b0, 64'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA0};
    tbl[1]  = '{1'b1, 1'b0, 64'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA0};
    tbl[2]  = '{1'b1, 1'b0, 64'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA0};
    tbl[3]  = '{1'b1, 1'b0, 64'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA0};
    tbl[4]  = '{1'b0, 1'b1, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA1};
    tbl[5]  = '{1'b0, 1'b1, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA2};
    tbl[6]  = '{1'b0, 1'b1, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA3};
    tbl[7]  = '{1'b0, 1'b1, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, 64'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 1'b0, 64'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h55};
    tbl[10] = '{1'b0, 1'b1, 64'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[11] = '{1'b1, 1'b1, 64'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h66};

    for (int i = 0; i < 12; i++) begin
      enq_en   = tbl[i].enq;
      deq_en   = tbl[i].deq;
      enq_data = tbl[i].data;
      @(posedge clk);
      #1;
      enq_en = 1'b0;
      deq_en = 1'b0;
      cmp1($sformatf("tbl%0d.notEmpty", i),   notEmpty,   tbl[i].ne);
      cmp1($sformatf("tbl%0d.notFull", i),    notFull,    tbl[i].nf);
      cmp1($sformatf("tbl%0d.almostFull", i), almostFull, tbl[i].af);
      cmp1($sformatf("tbl%0d.err", i),        err,        tbl[i].er);
      if (tbl[i].chk_first) cmpw($sformatf("tbl%0d.first", i), first, tbl[i].fst);
    end

    // Sticky error clears only on reset.
    do_reset();

    // Fill to full, overflow attempt, then drain the original 32 values.
    for (int i = 0; i < int'(N); i++) begin
      do_cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 64'h1000 + 64'(i));
      if (i == int'(N - TH) - 2) cmp1("afull_before", almostFull, 1'b0);
      if (i == int'(N - TH) - 1) cmp1("afull_at", almostFull, 1'b1);
    end
    cmp1("full_notFull", notFull, 1'b0);
    do_cycle("overflow", 1'b1, 1'b0, 64'hDEAD);
    for (int i = 0; i < int'(N); i++) begin
      cmpw($sformatf("drain%0d_val", i), first, 64'h1000 + 64'(i));
      do_cycle($sformatf("drain%0d", i), 1'b0, 1'b1, 64'h0);
    end

    // Full with simultaneous enq/deq: dequeue wins, enqueue dropped.
    do_reset();
    for (int i = 0; i < int'(N); i++) do_cycle("refill", 1'b1, 1'b0, 64'h2000 + 64'(i));
    do_cycle("full_both", 1'b1, 1'b1, 64'hBEEF);
    while (q.size() != 0) do_cycle("drain_fb", 1'b0, 1'b1, 64'h0);

    // Streaming with occupancy 1 across several pointer wraps.
    do_reset();
    do_cycle("prime", 1'b1, 1'b0, 64'h0);
    for (int i = 1; i <= 100; i++) do_cycle($sformatf("stream%0d", i), 1'b1, 1'b1, 64'(i));
    do_cycle("stream_end", 1'b0, 1'b1, 64'h0);

    // Reset mid-operation discards contents.
    do_reset();
    for (int i = 0; i < 10; i++) do_cycle("pre_rst", 1'b1, 1'b0, 64'h3000 + 64'(i));
    do_reset();
    do_cycle("post_rst_enq", 1'b1, 1'b0, 64'h77);
    do_cycle("post_rst_deq", 1'b0, 1'b1, 64'h0);

    // Constrained-random traffic respecting flow control, with alternating bias.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int pe;
      bit e;
      bit d;
      pe = ((i / 400) % 2 == 0) ? 75 : 30;
      e  = (int'($urandom_range(99)) < pe) && (q.size() < int'(N));
      d  = (int'($urandom_range(99)) < 55) && (q.size() > 0);
      if ($urandom_range(599) == 0) begin
        do_reset();
      end else begin
        do_cycle("rand", e, d, {$urandom, $urandom});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
